// File: rtl/cv32e40x_pkg.sv
// Shared divider types: operator encoding, FSM states and operator decode helpers.
// Pure declarations; no logic, no latency, no flow control.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV_DIV,
        DIV_DIVU,
        DIV_REM,
        DIV_REMU
    } div_opcode_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    function automatic logic div_is_signed(div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic div_is_rem(div_opcode_e op);
        return (op == DIV_REM) || (op == DIV_REMU);
    endfunction

endpackage

// File: rtl/cv32e40x_div_if.sv
// EX-stage <-> divider handshake bundle: valid_i/ready_o upstream, valid_o/ready_i downstream.
// The master (EX stage) holds operator and operands stable while valid_i is high.
interface cv32e40x_div_if #(
    parameter int unsigned DIV_WIDTH = 32
) ();
    import cv32e40x_pkg::*;

    logic                 valid_i;
    div_opcode_e          operator_i;
    logic [DIV_WIDTH-1:0] op_a_i;
    logic [DIV_WIDTH-1:0] op_b_i;
    logic [DIV_WIDTH-1:0] result_o;
    logic                 ready_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (
        output valid_i, operator_i, op_a_i, op_b_i, ready_i,
        input  result_o, ready_o, valid_o
    );

    modport slave (
        input  valid_i, operator_i, op_a_i, op_b_i, ready_i,
        output result_o, ready_o, valid_o
    );

endinterface

// File: rtl/cv32e40x_div_step.sv
// One combinational restoring-division step on magnitudes: shift, compare, subtract, quotient bit.
// Zero latency; no flow control.
module cv32e40x_div_step #(
    parameter int unsigned DIV_WIDTH = 32
) (
    input  logic [DIV_WIDTH-1:0] rem,
    input  logic [DIV_WIDTH-1:0] quo,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_next,
    output logic [DIV_WIDTH-1:0] quo_next
);

    logic [DIV_WIDTH:0] rem_shift;
    logic [DIV_WIDTH:0] diff;
    logic               ge;

    // rem < divisor holds between steps, so rem_shift < 2*divisor and the
    // top bit of the W+1 difference is a valid sign whenever rem_shift < 2^W.
    always_comb begin
        rem_shift = {rem, quo[DIV_WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor};
        ge        = rem_shift[DIV_WIDTH] | ~diff[DIV_WIDTH];
        rem_next  = ge ? diff[DIV_WIDTH-1:0] : rem_shift[DIV_WIDTH-1:0];
        quo_next  = {quo[DIV_WIDTH-2:0], ge};
    end

endmodule

// File: rtl/cv32e40x_div.sv
// Iterative radix-2 DIV/DIVU/REM/REMU: DIV_WIDTH+1 cycles, or 1 cycle for b==0, overflow and early-out.
// Result holds in DIV_DONE until ready_i; valid_i low kills the operation in any state.
module cv32e40x_div #(
    parameter int unsigned DIV_WIDTH    = 32,
    parameter bit          EARLY_OUT_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    cv32e40x_div_if.slave div_if
);
    import cv32e40x_pkg::*;

    localparam int unsigned CNT_W = $clog2(DIV_WIDTH);

    div_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DIV_WIDTH-1:0] rem_q;
    logic [DIV_WIDTH-1:0] quo_q;
    logic [DIV_WIDTH-1:0] divisor_q;
    logic                 quo_neg_q;
    logic                 rem_neg_q;
    logic                 rem_sel_q;

    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [DIV_WIDTH-1:0] a_abs;
    logic [DIV_WIDTH-1:0] b_abs;
    logic                 b_zero;
    logic                 ovf;
    logic                 early;
    logic [DIV_WIDTH-1:0] step_rem;
    logic [DIV_WIDTH-1:0] step_quo;
    logic [DIV_WIDTH-1:0] quo_res;
    logic [DIV_WIDTH-1:0] rem_res;

    always_comb begin
        op_signed = div_is_signed(div_if.operator_i);
        a_neg     = op_signed & div_if.op_a_i[DIV_WIDTH-1];
        b_neg     = op_signed & div_if.op_b_i[DIV_WIDTH-1];
        a_abs     = a_neg ? -div_if.op_a_i : div_if.op_a_i;
        b_abs     = b_neg ? -div_if.op_b_i : div_if.op_b_i;
        b_zero    = (div_if.op_b_i == '0);
        ovf       = op_signed && (div_if.op_a_i == {1'b1, {(DIV_WIDTH-1){1'b0}}})
                              && (div_if.op_b_i == '1);
        early     = EARLY_OUT_EN && !b_zero && (a_abs < b_abs);
    end

    cv32e40x_div_step #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (!div_if.valid_i) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    divisor_q <= b_abs;
                    quo_neg_q <= a_neg ^ b_neg;
                    rem_neg_q <= a_neg;
                    rem_sel_q <= div_is_rem(div_if.operator_i);
                    // Remainder registers hold |a| so the sign fix-up restores a exactly.
                    if (b_zero) begin
                        quo_q     <= '1;
                        rem_q     <= a_abs;
                        quo_neg_q <= 1'b0;
                        state_q   <= DIV_DONE;
                    end else if (ovf) begin
                        quo_q     <= {1'b1, {(DIV_WIDTH-1){1'b0}}};
                        rem_q     <= '0;
                        quo_neg_q <= 1'b0;
                        state_q   <= DIV_DONE;
                    end else if (early) begin
                        quo_q   <= '0;
                        rem_q   <= a_abs;
                        state_q <= DIV_DONE;
                    end else begin
                        quo_q   <= a_abs;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(DIV_WIDTH - 1);
                        state_q <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    if (cnt_q == '0) begin
                        state_q <= DIV_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (div_if.ready_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        quo_res         = quo_neg_q ? -quo_q : quo_q;
        rem_res         = rem_neg_q ? -rem_q : rem_q;
        div_if.result_o = '0;
        if (state_q == DIV_DONE) begin
            div_if.result_o = rem_sel_q ? rem_res : quo_res;
        end
    end

    assign div_if.valid_o = div_if.valid_i && (state_q == DIV_DONE);
    assign div_if.ready_o = !div_if.valid_i || ((state_q == DIV_DONE) && div_if.ready_i);

endmodule

// File: tb/tb_cv32e40x_div.sv
// Directed-vector bench for cv32e40x_div with a queue scoreboard checked by a negedge monitor.
// Stimulus drives at posedge+1; monitor compares result and latency whenever valid_o is high.
module tb_cv32e40x_div;
    import cv32e40x_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          lat;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   op_id = 0;
    exp_t exp_q[$];
    exp_t head;
    bit   head_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cv32e40x_div_if #(.DIV_WIDTH(32)) div_if ();

    cv32e40x_div #(
        .DIV_WIDTH    (32),
        .EARLY_OUT_EN (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (div_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every cycle valid_o is high must match the head entry.
    always @(negedge clk) begin
        if (!rst && div_if.valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid_o=1 result 0x%08h, required no pending result",
                         div_if.result_o);
            end else begin
                head = exp_q[0];
                if (!head_seen) begin
                    check($sformatf("latency_op%0d", head.id), 32'(cyc - head.start), 32'(head.lat));
                    head_seen = 1'b1;
                end
                check($sformatf("result_op%0d", head.id), div_if.result_o, head.res);
                if (div_if.ready_i) begin
                    void'(exp_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic run_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat, input int stall);
        exp_t e;
        bit   got;
        e.id    = op_id;
        e.res   = res;
        e.lat   = lat;
        e.start = cyc;
        op_id++;
        exp_q.push_back(e);
        div_if.valid_i    = 1'b1;
        div_if.operator_i = op;
        div_if.op_a_i     = a;
        div_if.op_b_i     = b;
        div_if.ready_i    = (stall == 0);
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            got = div_if.valid_o;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_op%0d: valid_o still 0 after 80 cycles, required 1", e.id);
            void'(exp_q.pop_back());
        end else if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                check("bp_ready_low", 32'(div_if.ready_o), 32'd0);
                @(posedge clk);
                #1;
            end
            div_if.ready_i = 1'b1;
            #1;
            check("bp_ready_rise", 32'(div_if.ready_o), 32'd1);
        end else begin
            check("retire_ready", 32'(div_if.ready_o), 32'd1);
        end
        @(posedge clk);
        #1;
        div_if.valid_i = 1'b0;
        div_if.ready_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        div_if.valid_i    = 1'b0;
        div_if.operator_i = DIV_DIVU;
        div_if.op_a_i     = '0;
        div_if.op_b_i     = '0;
        div_if.ready_i    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(div_if.valid_o), 32'd0);
        check("reset_ready", 32'(div_if.ready_o), 32'd1);
        check("reset_result", div_if.result_o, 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(DIV_IDLE));
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(DIV_DIVU, 32'd100,        32'd7,          32'd14,         33, 0);
        run_op(DIV_REMU, 32'd100,        32'd7,          32'd2,          33, 0);
        run_op(DIV_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0);
        run_op(DIV_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0);
        run_op(DIV_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, 0);
        run_op(DIV_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0);
        run_op(DIV_REMU, 32'd5,          32'd0,          32'd5,          1,  0);
        run_op(DIV_DIV,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1,  0);
        run_op(DIV_REM,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1,  0);
        run_op(DIV_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
        run_op(DIV_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
        run_op(DIV_DIVU, 32'd3,          32'd10,         32'd0,          1,  0);
        run_op(DIV_REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  1,  0);
        run_op(DIV_DIV,  32'd5,          32'hFFFF_FFF7,  32'd0,          1,  0);
        run_op(DIV_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33, 0);
        run_op(DIV_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33, 0);
        run_op(DIV_REM,  32'hFFFF_FFF8,  32'd4,          32'd0,          33, 0);
        run_op(DIV_DIVU, 32'd7,          32'd7,          32'd1,          33, 0);
        run_op(DIV_DIVU, 32'd100,        32'd7,          32'd14,         33, 5);

        // Kill mid-iteration, then an immediate request.
        div_if.valid_i    = 1'b1;
        div_if.operator_i = DIV_DIVU;
        div_if.op_a_i     = 32'd1000;
        div_if.op_b_i     = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        check("busy_ready", 32'(div_if.ready_o), 32'd0);
        check("busy_valid", 32'(div_if.valid_o), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        div_if.valid_i = 1'b0;
        #1;
        check("kill_ready", 32'(div_if.ready_o), 32'd1);
        check("kill_valid", 32'(div_if.valid_o), 32'd0);
        @(posedge clk);
        #1;
        check("kill_state", 32'(dut.state_q), 32'(DIV_IDLE));
        run_op(DIV_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

        // Kill in DIV_DONE takes priority over retire.
        div_if.valid_i    = 1'b1;
        div_if.operator_i = DIV_DIVU;
        div_if.op_a_i     = 32'd5;
        div_if.op_b_i     = 32'd0;
        @(posedge clk);
        #1;
        check("done_state", 32'(dut.state_q), 32'(DIV_DONE));
        div_if.valid_i = 1'b0;
        #1;
        check("done_kill_valid", 32'(div_if.valid_o), 32'd0);
        check("done_kill_ready", 32'(div_if.ready_o), 32'd1);
        @(posedge clk);
        #1;
        check("done_kill_state", 32'(dut.state_q), 32'(DIV_IDLE));

        // Asynchronous reset during iteration.
        div_if.valid_i    = 1'b1;
        div_if.operator_i = DIV_DIV;
        div_if.op_a_i     = 32'hFFFF_FF9C;
        div_if.op_b_i     = 32'd7;
        repeat (12) @(posedge clk);
        #1;
        check("pre_rst_state", 32'(dut.state_q), 32'(DIV_BUSY));
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(div_if.valid_o), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(DIV_IDLE));
        check("rst_cnt", 32'(dut.cnt_q), 32'd0);
        check("rst_quo", dut.quo_q, 32'd0);
        div_if.valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(DIV_DIV, 32'd20, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 33, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
